// File: rtl/cache_controller_if.sv
// Bus bundle for the cache controller: the core request/response channel
// and the line-granular memory refill/writeback channel.
interface cache_controller_if #(
    parameter int ADDR_W     = 27,
    parameter int MEM_ADDR_W = 23,
    parameter int LINE_W     = 128
);
    logic                  core2cache_rd_en;
    logic [ADDR_W-1:0]     core2cache_rd_addr;
    logic                  core2cache_wr_en;
    logic [ADDR_W-1:0]     core2cache_wr_addr;
    logic [31:0]           core2cache_wr_data;
    logic                  cache2core_rd_fin;
    logic [31:0]           cache2core_rd_data;
    logic                  cache2core_wr_fin;
    logic [MEM_ADDR_W-1:0] cache2mem_addr;
    logic                  cache2mem_rd_req;
    logic                  mem2cache_rd_valid;
    logic [LINE_W-1:0]     mem2cache_rd_data;
    logic                  cache2mem_wr_req;
    logic [LINE_W-1:0]     cache2mem_wr_data;
    logic                  mem2cache_wr_ack;

    // The cache itself: serves the core, masters the memory side.
    modport slave (
        input  core2cache_rd_en, core2cache_rd_addr,
        input  core2cache_wr_en, core2cache_wr_addr, core2cache_wr_data,
        output cache2core_rd_fin, cache2core_rd_data, cache2core_wr_fin,
        output cache2mem_addr, cache2mem_rd_req, cache2mem_wr_req, cache2mem_wr_data,
        input  mem2cache_rd_valid, mem2cache_rd_data, mem2cache_wr_ack
    );

    // The environment: issues core requests and answers memory traffic.
    modport master (
        output core2cache_rd_en, core2cache_rd_addr,
        output core2cache_wr_en, core2cache_wr_addr, core2cache_wr_data,
        input  cache2core_rd_fin, cache2core_rd_data, cache2core_wr_fin,
        input  cache2mem_addr, cache2mem_rd_req, cache2mem_wr_req, cache2mem_wr_data,
        output mem2cache_rd_valid, mem2cache_rd_data, mem2cache_wr_ack
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with one outstanding
// request (or a write+read pair issued together, write served first).
module cache_controller #(
    parameter int TAG_W    = 13,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 4,
    parameter int LINE_W   = 128
) (
    input  logic              clk,
    input  logic              rstn,
    cache_controller_if.slave bus
);
    localparam int ADDR_W  = TAG_W + INDEX_W + OFFSET_W;
    localparam int WADDR_W = ADDR_W - 2;
    localparam int SEL_W   = OFFSET_W - 2;
    localparam int LINES   = 1 << INDEX_W;
    localparam int MADDR_W = TAG_W + INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_REFILL,
        S_UPDATE,
        S_RESPOND
    } state_t;

    state_t               state_q, state_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [LINES-1:0]     dirty_q, dirty_d;
    logic                 cur_wr_q, cur_wr_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [WADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [WADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]          wr_word_q, wr_word_d;
    logic [LINE_W-1:0]    fill_line_q, fill_line_d;
    logic                 rd_fin_q, rd_fin_d;
    logic                 wr_fin_q, wr_fin_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic [MADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                 mem_rd_req_q, mem_rd_req_d;
    logic                 mem_wr_req_q, mem_wr_req_d;
    logic [LINE_W-1:0]    mem_wr_data_q, mem_wr_data_d;

    logic [TAG_W-1:0]     tag_ram [LINES];
    logic [LINE_W-1:0]    data_ram [LINES];
    logic [TAG_W-1:0]     tag_rdata;
    logic [LINE_W-1:0]    data_rdata;
    logic                 ram_ren;
    logic                 ram_we;
    logic [INDEX_W-1:0]   ram_raddr;
    logic [LINE_W-1:0]    ram_wline;

    logic [WADDR_W-1:0]   cur_waddr;
    logic [TAG_W-1:0]     cur_tag;
    logic [INDEX_W-1:0]   cur_idx;
    logic [SEL_W-1:0]     cur_sel;
    logic                 hit;
    logic [LINE_W-1:0]    upd_line;

    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                     input logic [SEL_W-1:0]  sel,
                                                     input logic [31:0]       word);
        logic [LINE_W-1:0] r;
        r = line;
        r[32*sel +: 32] = word;
        return r;
    endfunction

    function automatic logic [31:0] select_word(input logic [LINE_W-1:0] line,
                                                input logic [SEL_W-1:0]  sel);
        return line[32*sel +: 32];
    endfunction

    function automatic logic [INDEX_W-1:0] index_of(input logic [WADDR_W-1:0] waddr);
        return waddr[SEL_W +: INDEX_W];
    endfunction

    // Only word addresses are kept; the request being served is the write
    // while cur_wr is set, otherwise the read.
    assign cur_waddr = cur_wr_q ? wr_addr_q : rd_addr_q;
    assign cur_tag   = cur_waddr[WADDR_W-1 -: TAG_W];
    assign cur_idx   = index_of(cur_waddr);
    assign cur_sel   = cur_waddr[SEL_W-1:0];
    assign hit       = valid_q[cur_idx] && (tag_rdata == cur_tag);
    assign upd_line  = cur_wr_q ? merge_word(fill_line_q, cur_sel, wr_word_q) : fill_line_q;

    // Tag and data arrays: synchronous read, no reset (contents qualified by valid).
    always_ff @(posedge clk) begin
        if (ram_we) begin
            tag_ram[cur_idx]  <= cur_tag;
            data_ram[cur_idx] <= ram_wline;
        end
        if (ram_ren) begin
            tag_rdata  <= tag_ram[ram_raddr];
            data_rdata <= data_ram[ram_raddr];
        end
    end

    // Next-state, request bookkeeping, array writes and registered outputs.
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        cur_wr_d      = cur_wr_q;
        rd_pend_d     = rd_pend_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_word_d     = wr_word_q;
        fill_line_d   = fill_line_q;
        rd_fin_d      = 1'b0;
        wr_fin_d      = 1'b0;
        rd_data_d     = rd_data_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_req_d  = mem_rd_req_q;
        mem_wr_req_d  = mem_wr_req_q;
        mem_wr_data_d = mem_wr_data_q;
        ram_ren       = 1'b0;
        ram_we        = 1'b0;
        ram_raddr     = cur_idx;
        ram_wline     = upd_line;

        case (state_q)
            S_IDLE: begin
                if (bus.core2cache_rd_en || bus.core2cache_wr_en) begin
                    if (bus.core2cache_rd_en) begin
                        rd_addr_d = bus.core2cache_rd_addr[ADDR_W-1:2];
                    end
                    if (bus.core2cache_wr_en) begin
                        wr_addr_d = bus.core2cache_wr_addr[ADDR_W-1:2];
                        wr_word_d = bus.core2cache_wr_data;
                    end
                    cur_wr_d  = bus.core2cache_wr_en;
                    rd_pend_d = bus.core2cache_wr_en && bus.core2cache_rd_en;
                    ram_ren   = 1'b1;
                    ram_raddr = bus.core2cache_wr_en ?
                                index_of(bus.core2cache_wr_addr[ADDR_W-1:2]) :
                                index_of(bus.core2cache_rd_addr[ADDR_W-1:2]);
                    state_d   = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (hit) begin
                    if (cur_wr_q) begin
                        ram_we           = 1'b1;
                        ram_wline        = merge_word(data_rdata, cur_sel, wr_word_q);
                        dirty_d[cur_idx] = 1'b1;
                        wr_fin_d         = 1'b1;
                    end else begin
                        rd_fin_d  = 1'b1;
                        rd_data_d = select_word(data_rdata, cur_sel);
                    end
                    state_d = S_RESPOND;
                end else if (valid_q[cur_idx] && dirty_q[cur_idx]) begin
                    mem_addr_d    = {tag_rdata, cur_idx};
                    mem_wr_data_d = data_rdata;
                    mem_wr_req_d  = 1'b1;
                    state_d       = S_WRITEBACK;
                end else begin
                    mem_addr_d   = {cur_tag, cur_idx};
                    mem_rd_req_d = 1'b1;
                    state_d      = S_REFILL;
                end
            end

            S_WRITEBACK: begin
                if (bus.mem2cache_wr_ack) begin
                    mem_wr_req_d = 1'b0;
                    mem_rd_req_d = 1'b1;
                    mem_addr_d   = {cur_tag, cur_idx};
                    state_d      = S_REFILL;
                end
            end

            S_REFILL: begin
                if (bus.mem2cache_rd_valid) begin
                    mem_rd_req_d = 1'b0;
                    fill_line_d  = bus.mem2cache_rd_data;
                    state_d      = S_UPDATE;
                end
            end

            S_UPDATE: begin
                ram_we           = 1'b1;
                ram_wline        = upd_line;
                valid_d[cur_idx] = 1'b1;
                dirty_d[cur_idx] = cur_wr_q;
                if (cur_wr_q) begin
                    wr_fin_d = 1'b1;
                end else begin
                    rd_fin_d  = 1'b1;
                    rd_data_d = select_word(upd_line, cur_sel);
                end
                state_d = S_RESPOND;
            end

            S_RESPOND: begin
                if (rd_pend_q) begin
                    cur_wr_d  = 1'b0;
                    rd_pend_d = 1'b0;
                    ram_ren   = 1'b1;
                    ram_raddr = index_of(rd_addr_q);
                    state_d   = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any memory transaction and invalidates all lines.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            valid_q       <= '0;
            dirty_q       <= '0;
            cur_wr_q      <= 1'b0;
            rd_pend_q     <= 1'b0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            wr_word_q     <= '0;
            fill_line_q   <= '0;
            rd_fin_q      <= 1'b0;
            wr_fin_q      <= 1'b0;
            rd_data_q     <= '0;
            mem_addr_q    <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_wr_req_q  <= 1'b0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            dirty_q       <= dirty_d;
            cur_wr_q      <= cur_wr_d;
            rd_pend_q     <= rd_pend_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_word_q     <= wr_word_d;
            fill_line_q   <= fill_line_d;
            rd_fin_q      <= rd_fin_d;
            wr_fin_q      <= wr_fin_d;
            rd_data_q     <= rd_data_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_wr_req_q  <= mem_wr_req_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign bus.cache2core_rd_fin  = rd_fin_q;
    assign bus.cache2core_rd_data = rd_data_q;
    assign bus.cache2core_wr_fin  = wr_fin_q;
    assign bus.cache2mem_addr     = mem_addr_q;
    assign bus.cache2mem_rd_req   = mem_rd_req_q;
    assign bus.cache2mem_wr_req   = mem_wr_req_q;
    assign bus.cache2mem_wr_data  = mem_wr_data_q;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: hits, misses, writeback, paired
// write+read, busy-time requests and reset in the middle of a refill.
module tb_cache_controller;
    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int checks          = 0;
    int errors          = 0;
    int rd_fin_count    = 0;
    int wr_fin_count    = 0;
    int rd_req_cycles   = 0;
    int wr_req_cycles   = 0;
    int both_req_cycles = 0;

    cache_controller_if bus ();

    cache_controller dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Event counters sampled on the falling edge, midway between active edges.
    always @(negedge clk) begin
        if (bus.cache2core_rd_fin) rd_fin_count++;
        if (bus.cache2core_wr_fin) wr_fin_count++;
        if (bus.cache2mem_rd_req) rd_req_cycles++;
        if (bus.cache2mem_wr_req) wr_req_cycles++;
        if (bus.cache2mem_rd_req && bus.cache2mem_wr_req) both_req_cycles++;
    end

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Present one cycle of core request inputs, then return them to idle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [26:0] rd_addr,
                                 input logic [26:0] wr_addr, input logic [31:0] wr_data);
        bus.core2cache_rd_en   = rd;
        bus.core2cache_rd_addr = rd_addr;
        bus.core2cache_wr_en   = wr;
        bus.core2cache_wr_addr = wr_addr;
        bus.core2cache_wr_data = wr_data;
        tick();
        bus.core2cache_rd_en   = 1'b0;
        bus.core2cache_wr_en   = 1'b0;
    endtask

    // Wait (bounded) for a refill request and check its line address.
    task automatic waitRdReq(input string tag, input logic [22:0] addr);
        int n = 0;
        while (!bus.cache2mem_rd_req && n < 100) begin
            tick();
            n++;
        end
        checkOutput({tag, "_rd_req"}, bus.cache2mem_rd_req, 1'b1);
        checkOutput({tag, "_rd_addr"}, bus.cache2mem_addr, addr);
    endtask

    // Answer a refill one cycle late and check the request is held then dropped.
    task automatic serviceRefill(input string tag, input logic [22:0] addr, input logic [127:0] line);
        waitRdReq(tag, addr);
        tick();
        checkOutput({tag, "_rd_hold"}, bus.cache2mem_rd_req, 1'b1);
        bus.mem2cache_rd_valid = 1'b1;
        bus.mem2cache_rd_data  = line;
        tick();
        bus.mem2cache_rd_valid = 1'b0;
        bus.mem2cache_rd_data  = '0;
        checkOutput({tag, "_rd_drop"}, bus.cache2mem_rd_req, 1'b0);
    endtask

    // Wait (bounded) for a fin pulse, check its data, its one-cycle width and data hold.
    task automatic waitFin(input string tag, input logic is_rd, input logic [31:0] data);
        int n = 0;
        while (!(is_rd ? bus.cache2core_rd_fin : bus.cache2core_wr_fin) && n < 100) begin
            tick();
            n++;
        end
        checkOutput({tag, "_fin"}, is_rd ? bus.cache2core_rd_fin : bus.cache2core_wr_fin, 1'b1);
        if (is_rd) checkOutput({tag, "_data"}, bus.cache2core_rd_data, data);
        tick();
        checkOutput({tag, "_fin_drop"}, is_rd ? bus.cache2core_rd_fin : bus.cache2core_wr_fin, 1'b0);
        if (is_rd) checkOutput({tag, "_data_hold"}, bus.cache2core_rd_data, data);
    endtask

    // A hit: fin exactly two cycles after the request and no memory traffic.
    task automatic checkHit(input string tag, input logic is_rd, input logic [26:0] addr, input logic [31:0] data);
        int req0;
        req0 = rd_req_cycles + wr_req_cycles;
        applyStimulus(is_rd, !is_rd, addr, addr, data);
        checkOutput({tag, "_early"}, is_rd ? bus.cache2core_rd_fin : bus.cache2core_wr_fin, 1'b0);
        tick();
        checkOutput({tag, "_fin"}, is_rd ? bus.cache2core_rd_fin : bus.cache2core_wr_fin, 1'b1);
        if (is_rd) checkOutput({tag, "_data"}, bus.cache2core_rd_data, data);
        tick();
        checkOutput({tag, "_fin_drop"}, is_rd ? bus.cache2core_rd_fin : bus.cache2core_wr_fin, 1'b0);
        checkOutput({tag, "_no_mem"}, rd_req_cycles + wr_req_cycles, req0);
    endtask

    // Check every output is at its reset value.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rd_fin"}, bus.cache2core_rd_fin, 1'b0);
        checkOutput({tag, "_wr_fin"}, bus.cache2core_wr_fin, 1'b0);
        checkOutput({tag, "_rd_data"}, bus.cache2core_rd_data, 32'h0);
        checkOutput({tag, "_rd_req"}, bus.cache2mem_rd_req, 1'b0);
        checkOutput({tag, "_wr_req"}, bus.cache2mem_wr_req, 1'b0);
        checkOutput({tag, "_addr"}, bus.cache2mem_addr, 23'h0);
        checkOutput({tag, "_wr_data"}, bus.cache2mem_wr_data, 128'h0);
    endtask

    // Main directed sequence.
    initial begin
        int n;
        int rd0;
        int wr0;
        int wreq0;

        bus.core2cache_rd_en   = 1'b0;
        bus.core2cache_rd_addr = '0;
        bus.core2cache_wr_en   = 1'b0;
        bus.core2cache_wr_addr = '0;
        bus.core2cache_wr_data = '0;
        bus.mem2cache_rd_valid = 1'b0;
        bus.mem2cache_rd_data  = '0;
        bus.mem2cache_wr_ack   = 1'b0;

        tick();
        tick();
        checkResetOutputs("reset");
        rstn = 1'b1;
        tick();

        applyStimulus(1'b1, 1'b0, 27'h0000014, 27'h0, 32'h0);
        serviceRefill("miss1", 23'h000001, 128'h44444444_33333333_22222222_11111111);
        waitFin("miss1", 1'b1, 32'h22222222);
        checkHit("hit1", 1'b1, 27'h0000014, 32'h22222222);

        checkHit("whit", 1'b0, 27'h0000014, 32'hDEADBEEF);
        checkHit("rhit_after_w", 1'b1, 27'h0000014, 32'hDEADBEEF);

        applyStimulus(1'b1, 1'b0, 27'h4000014, 27'h0, 32'h0);
        n = 0;
        while (!bus.cache2mem_wr_req && n < 100) begin
            tick();
            n++;
        end
        checkOutput("wb_req", bus.cache2mem_wr_req, 1'b1);
        checkOutput("wb_addr", bus.cache2mem_addr, 23'h000001);
        checkOutput("wb_data", bus.cache2mem_wr_data, 128'h44444444_33333333_DEADBEEF_11111111);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("wb_hold_req", bus.cache2mem_wr_req, 1'b1);
            checkOutput("wb_hold_addr", bus.cache2mem_addr, 23'h000001);
            checkOutput("wb_hold_data", bus.cache2mem_wr_data, 128'h44444444_33333333_DEADBEEF_11111111);
            checkOutput("wb_no_rd_req", bus.cache2mem_rd_req, 1'b0);
        end
        bus.mem2cache_wr_ack = 1'b1;
        tick();
        bus.mem2cache_wr_ack = 1'b0;
        checkOutput("wb_drop", bus.cache2mem_wr_req, 1'b0);
        serviceRefill("wb_refill", 23'h400001, 128'h88888888_77777777_66666666_55555555);
        waitFin("wb_refill", 1'b1, 32'h66666666);

        wreq0 = wr_req_cycles;
        applyStimulus(1'b0, 1'b1, 27'h0, 27'h0000200, 32'h12345678);
        serviceRefill("wmiss", 23'h000020, 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D);
        waitFin("wmiss", 1'b0, 32'h0);
        checkOutput("wmiss_no_wb", wr_req_cycles, wreq0);
        checkHit("wmiss_rd0", 1'b1, 27'h0000200, 32'h12345678);
        checkHit("wmiss_rd1", 1'b1, 27'h0000204, 32'h0BADF00D);

        rd0 = rd_fin_count;
        wr0 = wr_fin_count;
        applyStimulus(1'b1, 1'b1, 27'h0000300, 27'h0000300, 32'hA5A5A5A5);
        waitRdReq("pair_busy", 23'h000030);
        applyStimulus(1'b1, 1'b0, 27'h0000014, 27'h0, 32'h0);
        serviceRefill("pair", 23'h000030, 128'h0);
        waitFin("pair_wr", 1'b0, 32'h0);
        checkOutput("pair_rd_not_first", rd_fin_count - rd0, 0);
        waitFin("pair_rd", 1'b1, 32'hA5A5A5A5);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("pair_rd_fins", rd_fin_count - rd0, 1);
        checkOutput("pair_wr_fins", wr_fin_count - wr0, 1);

        applyStimulus(1'b1, 1'b0, 27'h0000400, 27'h0, 32'h0);
        waitRdReq("rst_mid", 23'h000040);
        rstn = 1'b0;
        #1;
        checkResetOutputs("rst_mid");
        tick();
        rstn = 1'b1;
        rd0 = rd_fin_count;
        bus.mem2cache_rd_valid = 1'b1;
        bus.mem2cache_rd_data  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
        tick();
        bus.mem2cache_rd_valid = 1'b0;
        bus.mem2cache_rd_data  = '0;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("late_valid_no_fin", rd_fin_count - rd0, 0);
        checkOutput("late_valid_no_req", bus.cache2mem_rd_req, 1'b0);
        applyStimulus(1'b1, 1'b0, 27'h0000014, 27'h0, 32'h0);
        serviceRefill("post_rst", 23'h000001, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        waitFin("post_rst", 1'b1, 32'hBBBBBBBB);

        checkOutput("req_exclusive", both_req_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
Direct-mapped, write-back, write-allocate data cache between the core request port (rd_en/wr_en pulse, rd_fin/wr_fin pulse) and a 128-bit line-granular memory port. Address is 27 bits: tag [26:14], index [13:4], byte offset [3:0]. Each line is 16 bytes (4 words) and the word select is addr[3:2]. The block takes single outstanding requests from the core/debug-core stage and issues line refills and writebacks downstream.

Parameters:
TAG_W, 13, tag width
INDEX_W, 10, index width (2^INDEX_W lines)
OFFSET_W, 4, byte offset width (line = 2^OFFSET_W bytes)
LINE_W, 128, line width in bits

Ports:
clk  in  1  clock, all logic on posedge
rstn  in  1  reset, asynchronous, active-low
core2cache_rd_en  in  1  one-cycle read request pulse
core2cache_rd_addr  in  27  read byte address
core2cache_wr_en  in  1  one-cycle write request pulse
core2cache_wr_addr  in  27  write byte address
core2cache_wr_data  in  32  write word
cache2core_rd_fin  out  1  one-cycle read completion pulse
cache2core_rd_data  out  32  read word, valid while rd_fin=1
cache2core_wr_fin  out  1  one-cycle write completion pulse
cache2mem_addr  out  23  line address {tag,index}
cache2mem_rd_req  out  1  refill request, level
mem2cache_rd_valid  in  1  refill data valid, one cycle
mem2cache_rd_data  in  128  refill line
cache2mem_wr_req  out  1  writeback request, level
cache2mem_wr_data  out  128  writeback line
mem2cache_wr_ack  in  1  writeback accepted, one cycle

Behaviour:
- Reset (async, rstn=0): all outputs 0; state IDLE; all valid and dirty bits cleared; pending-request latches cleared. Tag and data RAM contents are don't-care.
- Storage: valid[1024] and dirty[1024] in flops. Tag RAM is 1024x13 and data RAM is 1024x128, both with synchronous read. Word i = line[32i+31:32i].
- States: IDLE, LOOKUP, WRITEBACK, REFILL, UPDATE, RESPOND.
- IDLE: sample rd_en/wr_en. Latch addr/data for each asserted request and issue the tag/data RAM read for the head request. Next state is LOOKUP.
- Both rd_en and wr_en in the same cycle: both are latched. The write is serviced first, then the read. The read observes the written data.
- rd_en/wr_en asserted outside IDLE: ignored. No fin is generated for them.
- LOOKUP: hit = valid[idx] && tag==req_tag.
  - Read hit: go to RESPOND.
  - Write hit: merge the word, write the line, set dirty, go to RESPOND.
  - Miss with dirty line: go to WRITEBACK.
  - Miss otherwise: go to REFILL.
- Hit latency: fin is asserted exactly 2 cycles after the en cycle (en at cycle N, LOOKUP at N+1, fin at N+2). No memory traffic.
- WRITEBACK: drive cache2mem_addr={old_tag,idx}, wr_data=old line, wr_req=1. Hold all three stable until the wr_ack cycle. Drop wr_req the cycle after ack, then go to REFILL.
- REFILL: drive addr={req_tag,idx} and rd_req=1. Hold until the rd_valid cycle, then drop rd_req. Capture the line and go to UPDATE.
- UPDATE: write the line with the write word merged (for a write request), tag, valid=1, and dirty=(request is write). Go to RESPOND.
- RESPOND: pulse rd_fin with rd_data=selected word, or pulse wr_fin. Fins last exactly one cycle.
  - If a second latched request (read after write) is pending: issue its RAM read and go to LOOKUP.
  - Otherwise go to IDLE.
- rd_data is held at its last value after the fin.
- rd_req and wr_req are never high simultaneously.
- mem2cache_rd_valid or wr_ack arriving in a state not expecting it: ignored.
- Index wrap: none; index is taken directly from the address. A tag conflict at the same index always evicts.
- Reset mid-operation: memory requests deassert immediately and all lines become invalid. An in-flight memory transaction is abandoned and its late valid/ack is ignored.

Test Plan:
- Reset, then read 0x0000014 -> rd_req=1 with addr=0x000001. Mem returns 0x44444444_33333333_22222222_11111111 -> rd_fin with rd_data=0x22222222. Reread of the same address -> rd_fin exactly 2 cycles after rd_en, no rd_req.
- After the line is loaded, write 0xDEADBEEF to 0x0000014 -> wr_fin 2 cycles after wr_en, no mem traffic. Read 0x0000014 -> 0xDEADBEEF.
- Then read 0x4000014 (same index 1, tag 0x1000) -> wr_req with addr=0x000001 and wr_data=0x44444444_33333333_DEADBEEF_11111111. Hold wr_req 5 cycles before ack -> data stable. Then rd_req with addr=0x400001, then rd_fin.
- Write miss to clean/invalid line 0x0000200 data 0x12345678 -> refill only (no wr_req). Word 0 is merged, wr_fin follows. Reread returns 0x12345678 as a hit.
- rd_en and wr_en in the same cycle to 0x0000300 with data 0xA5A5A5A5 -> wr_fin first, then rd_fin on a later cycle with rd_data=0xA5A5A5A5. A third rd_en pulsed while busy -> no extra fin.
- rstn low for 1 cycle during REFILL (rd_req=1) -> all outputs 0 immediately. A late rd_valid is ignored. A subsequent read of a previously cached address misses (rd_req reissued).
